mc_command_arbiter: RTL

MC_COMMAND_ARBITER -- requirements
Module: mc_command_arbiter

---
 rtl/mc_command_arbiter_pkg.sv | 33 +++
 rtl/mc_frame_timer.sv | 27 ++
 rtl/mc_command_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mc_command_arbiter_pkg.sv
// Shared types and constants for the motor-controller command arbiter and its
// frame timing helpers.
package mc_command_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_NEUTRAL = 2'd0,
    ST_OWNED   = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_STOP    = 2'd3
  } arb_state_e;

  localparam logic [4:0] MC_NEUTRAL  = 5'b00001;

  localparam logic [1:0] DIR_ILLEGAL = 2'b00;
  localparam logic [1:0] DIR_NEUTRAL = 2'b01;
  localparam logic [1:0] DIR_FWD     = 2'b10;
  localparam logic [1:0] DIR_REV     = 2'b11;

  // Bit 0 is the most important source, so the lowest set bit wins.
  function automatic logic [2:0] pick_highest(input logic [2:0] req);
    logic [2:0] grant;
    grant = 3'b000;
    if (req[0])      grant = 3'b001;
    else if (req[1]) grant = 3'b010;
    else if (req[2]) grant = 3'b100;
    return grant;
  endfunction

  function automatic logic is_illegal(input logic [4:0] cmd);
    return (cmd[1:0] == DIR_ILLEGAL);
  endfunction

endpackage

// File: rtl/mc_frame_timer.sv
// Free-running frame counter; tick_o marks the last cycle of every frame.
module mc_frame_timer #(
  parameter int unsigned CYCLES = 1100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  assign tick_o = (count_q == LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (tick_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mc_command_arbiter.sv
// Frame-based arbiter choosing which source drives the motor-controller command,
// with emergency stop, preemption, an owner watchdog and illegal-direction trapping.
module mc_command_arbiter
  import mc_command_arbiter_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 1100000,
  parameter int unsigned WDOG_FRAMES  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       estop_i,
  input  logic [2:0] req_i,
  input  logic [2:0] upd_i,
  input  logic [4:0] cmd0_i,
  input  logic [4:0] cmd1_i,
  input  logic [4:0] cmd2_i,
  output logic [4:0] desired_mc_o,
  output logic [2:0] gnt_o,
  output logic       mc_update_o,
  output logic       timeout_o,
  output logic       cmd_err_o
);

  localparam int unsigned WDOG_W = $clog2(WDOG_FRAMES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_FRAMES);

  logic              tick;
  arb_state_e        state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [4:0]        desired_q, desired_d;
  logic              mc_update_q;
  logic              timeout_q;
  logic              cmd_err_q, cmd_err_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              upd_seen_q, upd_seen_d;

  logic              upd_seen_now;
  logic              owner_req;
  logic [2:0]        higher_req;
  logic              load_cmd;
  logic [4:0]        cmd_sel;

  mc_frame_timer #(
    .CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  // For a one-hot owner, gnt-1 masks exactly the more important sources.
  assign higher_req   = req_i & (gnt_q - 3'd1);
  assign owner_req    = |(req_i & gnt_q);
  assign upd_seen_now = upd_seen_q | (|(upd_i & gnt_q));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    desired_d  = desired_q;
    cmd_err_d  = cmd_err_q;
    wdog_d     = wdog_q;
    upd_seen_d = upd_seen_now;
    load_cmd   = 1'b0;
    cmd_sel    = cmd2_i;

    if (tick) begin
      upd_seen_d = 1'b0;
      if (estop_i) begin
        state_d   = ST_STOP;
        gnt_d     = 3'b000;
        desired_d = MC_NEUTRAL;
        wdog_d    = '0;
      end else begin
        case (state_q)
          ST_STOP: begin
            state_d   = ST_NEUTRAL;
            gnt_d     = 3'b000;
            desired_d = MC_NEUTRAL;
          end
          ST_NEUTRAL: begin
            if (|req_i) begin
              state_d  = ST_OWNED;
              gnt_d    = pick_highest(req_i);
              wdog_d   = '0;
              load_cmd = 1'b1;
            end
          end
          ST_OWNED, ST_TIMEOUT: begin
            if (|higher_req) begin
              state_d  = ST_OWNED;
              gnt_d    = pick_highest(higher_req);
              wdog_d   = '0;
              load_cmd = 1'b1;
            end else if (!owner_req) begin
              if (|req_i) begin
                state_d  = ST_OWNED;
                gnt_d    = pick_highest(req_i);
                wdog_d   = '0;
                load_cmd = 1'b1;
              end else begin
                state_d   = ST_NEUTRAL;
                gnt_d     = 3'b000;
                desired_d = MC_NEUTRAL;
                wdog_d    = '0;
              end
            end else if (state_q == ST_TIMEOUT) begin
              desired_d = MC_NEUTRAL;
            end else if (upd_seen_now) begin
              wdog_d   = '0;
              load_cmd = 1'b1;
            end else if ((wdog_q + WDOG_W'(1)) >= WDOG_LIMIT) begin
              state_d   = ST_TIMEOUT;
              wdog_d    = wdog_q + WDOG_W'(1);
              desired_d = MC_NEUTRAL;
            end else begin
              wdog_d   = wdog_q + WDOG_W'(1);
              load_cmd = 1'b1;
            end
          end
          default: begin
            state_d   = ST_NEUTRAL;
            gnt_d     = 3'b000;
            desired_d = MC_NEUTRAL;
          end
        endcase
      end
    end

    if (load_cmd) begin
      if (gnt_d[0])      cmd_sel = cmd0_i;
      else if (gnt_d[1]) cmd_sel = cmd1_i;
      else               cmd_sel = cmd2_i;
      if (is_illegal(cmd_sel)) begin
        desired_d = MC_NEUTRAL;
        cmd_err_d = 1'b1;
      end else begin
        desired_d = cmd_sel;
      end
    end
  end

  // desired_d only differs from desired_q on a tick, so the compare yields a one-cycle pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_NEUTRAL;
      gnt_q       <= 3'b000;
      desired_q   <= MC_NEUTRAL;
      mc_update_q <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      wdog_q      <= '0;
      upd_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      desired_q   <= desired_d;
      mc_update_q <= (desired_d != desired_q);
      timeout_q   <= (state_d == ST_TIMEOUT);
      cmd_err_q   <= cmd_err_d;
      wdog_q      <= wdog_d;
      upd_seen_q  <= upd_seen_d;
    end
  end

  assign desired_mc_o = desired_q;
  assign gnt_o        = gnt_q;
  assign mc_update_o  = mc_update_q;
  assign timeout_o    = timeout_q;
  assign cmd_err_o    = cmd_err_q;

endmodule
